// File: rtl/axil_lsu_bridge.sv
// Single-outstanding load/store bridge from the Z-Core execute stage onto an AXI4-Lite master port.
// Define AXIL_LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word requests without touching the bus.
module axil_lsu_bridge #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_DATA} state_e;

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            size_q, size_d, addr_lo_q, addr_lo_d;
  logic                  uns_q, uns_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;

  logic                  misalign_c;
  logic [ADDR_WIDTH-1:0] aligned_c;
  logic [DATA_W-1:0]     wrep_c, load_c;
  logic [STRB_W-1:0]     strb_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;

`ifdef AXIL_LSU_MISALIGN_CHECK_EN
  assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign aligned_c = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // Store lane replication and byte strobes for the incoming request
  always_comb begin
    wrep_c = req_wdata;
    strb_c = 4'b1111;
    case (req_size)
      2'b00: begin
        wrep_c = {4{req_wdata[7:0]}};
        strb_c = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wrep_c = {2{req_wdata[15:0]}};
        strb_c = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the registered request
  always_comb begin
    byte_c = m_axil_rdata[{addr_lo_q, 3'b000} +: 8];
    half_c = m_axil_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    load_c = m_axil_rdata;
    case (size_q)
      2'b00:   load_c = uns_q ? {24'h000000, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_c = uns_q ? {16'h0000, half_c} : {{16{half_c[15]}}, half_c};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    size_d       = size_q;
    addr_lo_d    = addr_lo_q;
    uns_d        = uns_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          size_d    = req_size;
          addr_lo_d = req_addr[1:0];
          uns_d     = req_unsigned;
          if (misalign_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = aligned_c;
            wdata_d   = wrep_c;
            wstrb_d   = strb_c;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
            araddr_d  = aligned_c;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && m_axil_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axil_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          state_d      = IDLE;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (m_axil_bresp != 2'b00);
        end
      end
      READ: begin
        if (m_axil_arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid) begin
          state_d      = IDLE;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = (m_axil_rresp != 2'b00);
          resp_rdata_d = (m_axil_rresp != 2'b00) ? '0 : load_c;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready returns only once the response pulse has been presented
    req_ready_d = (state_d == IDLE) && !resp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      size_q       <= 2'b00;
      addr_lo_q    <= 2'b00;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      size_q       <= size_d;
      addr_lo_q    <= addr_lo_d;
      uns_q        <= uns_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_lsu_bridge.sv
// Directed bench for axil_lsu_bridge with a small AXI4-Lite RAM slave model.
module tb_axil_lsu_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk = ~clk;

  axil_lsu_bridge #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
    .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
    .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
    .m_axil_rready(m_rready)
  );

  // Slave configuration, set by the stimulus between requests
  int         aw_delay = 0;
  logic       w_always = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  logic       b_hold = 1'b0;

  logic [31:0] mem [0:255];
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic        aw_hs, w_hs, wr_go;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;
  assign wr_go   = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr = aw_hs ? m_awaddr : aw_a;
  assign wr_data = w_hs ? m_wdata : w_d;
  assign wr_strb = w_hs ? m_wstrb : w_s;

  always @(posedge clk) begin
    if (!rstn) begin
      m_awready <= 1'b0; aw_cnt <= 0; m_wready <= 1'b0; m_arready <= 1'b0;
      m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rdata <= 32'h0; m_rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= 32'h0; w_d <= 32'h0; w_s <= 4'h0;
    end else begin
      if (m_awvalid && !m_awready) begin
        if (aw_cnt >= aw_delay) m_awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end else begin
        m_awready <= 1'b0;
        aw_cnt    <= 0;
      end
      m_wready  <= w_always ? 1'b1 : (m_wvalid && !m_wready);
      m_arready <= m_arvalid && !m_arready;
      if (aw_hs) aw_a <= m_awaddr;
      if (w_hs) begin w_d <= m_wdata; w_s <= m_wstrb; end
      if (wr_go) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) mem[wr_addr[9:2]][8*i +: 8] <= wr_data[8*i +: 8];
        if (!b_hold) begin m_bvalid <= 1'b1; m_bresp <= bresp_cfg; end
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs) w_got <= 1'b1;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr[9:2]];
        m_rresp  <= 2'b00;
      end else if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Results of the most recent request
  logic [31:0] r_rdata, c_awaddr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        r_err, r_got;
  int          r_lat, n_aw, n_w, n_ar;

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    r_got = 1'b0; r_lat = 0; n_aw = 0; n_w = 0; n_ar = 0;
    r_rdata = 32'h0; r_err = 1'b0; c_awaddr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0;
    while (!r_got && r_lat < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      r_lat++;
      if (m_awvalid) begin n_aw++; c_awaddr = m_awaddr; end
      if (m_wvalid) begin n_w++; c_wdata = m_wdata; c_wstrb = m_wstrb; end
      if (m_arvalid) n_ar++;
      if (resp_valid) begin r_got = 1'b1; r_rdata = resp_rdata; r_err = resp_err; end
    end
    check({tag, ".resp_seen"}, 32'(r_got), 32'd1);
    if (r_got) begin
      check({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      check({tag, ".resp_single"}, 32'(resp_valid), 32'd0);
      check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    end
  endtask

  int extra;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.valids", {28'h0, m_awvalid, m_wvalid, m_arvalid, 1'b0}, 32'h0);
    check("rst.readies", {30'h0, m_bready, m_rready}, 32'h0);
    check("rst.awaddr", m_awaddr, 32'h0);
    check("rst.araddr", m_araddr, 32'h0);
    check("rst.wdata", m_wdata, 32'h0);
    check("rst.wstrb", 32'(m_wstrb), 32'h0);
    rstn = 1'b1;

    do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    check("st_word.wstrb", 32'(c_wstrb), 32'hF);
    check("st_word.wdata", c_wdata, 32'hDEAD_BEEF);
    check("st_word.awaddr", c_awaddr, 32'h0000_0100);
    check("st_word.err", 32'(r_err), 32'd0);
    check("st_word.rdata", r_rdata, 32'h0);
    check("st_word.lat", 32'(r_lat), 32'd4);

    do_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    check("ld_word.rdata", r_rdata, 32'hDEAD_BEEF);
    check("ld_word.err", 32'(r_err), 32'd0);
    check("ld_word.lat", 32'(r_lat), 32'd4);
    check("ld_word.n_aw", 32'(n_aw), 32'd0);

    do_req("st_zero", 1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
    do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080);
    check("st_byte.wstrb", 32'(c_wstrb), 32'h8);
    check("st_byte.wdata", c_wdata, 32'h8080_8080);
    check("st_byte.awaddr", c_awaddr, 32'h0000_0100);
    do_req("st_half", 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_1234);
    check("st_half.wstrb", 32'(c_wstrb), 32'h3);
    check("st_half.wdata", c_wdata, 32'h1234_1234);
    do_req("ld_merged", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    check("ld_merged.rdata", r_rdata, 32'h8000_1234);

    do_req("ld_b3s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    check("ld_b3s.rdata", r_rdata, 32'hFFFF_FF80);
    do_req("ld_b3u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
    check("ld_b3u.rdata", r_rdata, 32'h0000_0080);
    do_req("ld_h2s", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
    check("ld_h2s.rdata", r_rdata, 32'hFFFF_8000);
    do_req("ld_h0u", 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0);
    check("ld_h0u.rdata", r_rdata, 32'h0000_1234);
    do_req("ld_b1s", 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0);
    check("ld_b1s.rdata", r_rdata, 32'h0000_0012);

    aw_delay = 2; w_always = 1'b1;
    do_req("bp", 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h1122_3344);
    check("bp.n_w", 32'(n_w), 32'd1);
    check("bp.n_aw", 32'(n_aw), 32'd4);
    check("bp.lat", 32'(r_lat), 32'd6);
    check("bp.err", 32'(r_err), 32'd0);
    aw_delay = 0; w_always = 1'b0;
    do_req("bp_ld", 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
    check("bp_ld.rdata", r_rdata, 32'h1122_3344);

    bresp_cfg = 2'b10;
    do_req("bresp", 1'b1, 2'b10, 1'b0, 32'h0000_0108, 32'h5555_AAAA);
    check("bresp.err", 32'(r_err), 32'd1);
    check("bresp.rdata", r_rdata, 32'h0);
    bresp_cfg = 2'b00;

    do_req("mis_word", 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
`ifdef AXIL_LSU_MISALIGN_CHECK_EN
    check("mis_word.err", 32'(r_err), 32'd1);
    check("mis_word.lat", 32'(r_lat), 32'd1);
    check("mis_word.n_ar", 32'(n_ar), 32'd0);
    check("mis_word.rdata", r_rdata, 32'h0);
`else
    check("mis_word.err", 32'(r_err), 32'd0);
    check("mis_word.lat", 32'(r_lat), 32'd4);
    check("mis_word.n_ar", 32'(n_ar), 32'd2);
    check("mis_word.rdata", r_rdata, 32'h8000_1234);
`endif

    // Abort a store while it waits for its write response
    b_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_010C; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    r_lat = 0;
    r_got = 1'b0;
    while (!r_got && r_lat < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      r_lat++;
      if (m_bready) r_got = 1'b1;
    end
    check("rstmid.in_wr_resp", 32'(r_got), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("rstmid.valids", {28'h0, m_awvalid, m_wvalid, m_arvalid, 1'b0}, 32'h0);
    check("rstmid.readies", {30'h0, m_bready, m_rready}, 32'h0);
    check("rstmid.req_ready", 32'(req_ready), 32'd1);
    check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    rstn = 1'b1;
    b_hold = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    check("rstmid.no_resp", 32'(extra), 32'd0);

    do_req("post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    check("post_rst.rdata", r_rdata, 32'h8000_1234);
    check("post_rst.lat", 32'(r_lat), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_lsu_bridge.md
# axil_lsu_bridge

Load/store bridge between the Z-Core execute stage and the AXI4-Lite interconnect. It sits directly upstream of the AXI4-Lite RAM and peripherals. It accepts one byte, halfword or word request at a time and issues the matching AXI4-Lite read or write with byte strobes. For loads, it extracts the addressed lanes and sign- or zero-extends them before returning a single-cycle response to the core.

## Interface
- ADDR_WIDTH, 32, AXI and request byte-address width; data width is fixed at 32 bits, strobe width at 4.
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge idle, request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  single-cycle response pulse; the core must take it.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  response carries an error (misalignment, or non-OKAY BRESP/RRESP).
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channels; addresses are ADDR_WIDTH, data is 32, strobe is 4, prot is 3 bits tied to 3'b000.

## Operation
- The state machine has five states: IDLE, WRITE, WR_RESP, READ, RD_DATA.
- **IDLE:** req_ready=1. On acceptance, the request is registered.
  - A store goes to WRITE.
  - A load goes to READ.
  - A misaligned request under check goes to IDLE and emits an error response the next cycle.
- **WRITE:**
  - awvalid and wvalid are asserted together.
  - Each valid drops independently after its handshake; acceptance is tracked in aw_done/w_done.
  - When both are done, go to WR_RESP.
  - Both handshakes in the same cycle are legal.
- **WR_RESP:** bready=1. On bvalid, go to IDLE and emit the response with resp_err = (bresp != 00).
- **READ:** arvalid=1 until arready, then go to RD_DATA.
- **RD_DATA:** rready=1. On rvalid, go to IDLE and emit the response with resp_err = (rresp != 00).
  - Lane shift: rdata >> (8*addr[1:0]).
  - Extension from bit 7 (byte) or bit 15 (halfword) per req_unsigned.
- **AXI address:** the registered address with bits [1:0] forced to 0.
- **Write data replication:**
  - byte: {4{b}}
  - halfword: {2{h}}
  - word: as-is
- **wstrb:**
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 << (2*addr[1])
  - word: 4'b1111
- **AXI valids:** once asserted, a valid stays high until its handshake; the bridge never withdraws a request.
- **Reset:** any state goes to IDLE. All valids, bready, rready and resp_valid drop to 0 and no response is emitted for the aborted request.

## Timing
- **Reset values:**
  - req_ready=1.
  - resp_valid, resp_err, and all AXI valid/ready outputs are 0.
  - resp_rdata, addresses and wdata are 0; wstrb is 0.
- AXI outputs are registered. awvalid/wvalid/arvalid rise the cycle after acceptance.
- resp_valid is registered and rises the cycle after the B or R handshake.
- req_ready is low from the cycle after acceptance through the cycle resp_valid is high.
- A new request is accepted at the earliest the cycle after resp_valid.
- Against a zero-wait slave (ready in the cycle after valid), latency from acceptance to resp_valid:
  - store: 4 cycles
  - load: 4 cycles
  - misaligned error: 1 cycle
- bvalid or rvalid arriving before the bridge reaches WR_RESP/RD_DATA cannot occur for a compliant slave and is not handled.

## Configuration
- **AXIL_LSU_MISALIGN_CHECK_EN defined:**
  - Misalignment is checked: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned request issues no AXI transaction and returns resp_err=1, resp_rdata=0 one cycle after acceptance.
- **Undefined:** there is no check.
  - Halfword uses addr[1] only.
  - Word ignores addr[1:0].
  - The transaction is always issued.

## Test plan
- **Word store then load:** store 0xDEADBEEF to 0x100, then load word from 0x100. Required: wstrb=1111, resp_err=0, load resp_rdata=0xDEADBEEF.
- **Byte and halfword stores:** with 0x100 holding 0x00000000, store byte 0x80 to 0x103 (wstrb=1000, wdata=0x80808080), then store halfword 0x1234 to 0x100 (wstrb=0011). A word load from 0x100 returns 0x80001234.
- **Sign/zero extension:** load byte from 0x103 signed gives 0xFFFFFF80; unsigned gives 0x00000080. Signed halfword from 0x102 gives 0xFFFF8000.
- **Backpressure:** slave holds awready low for 3 cycles while wready is immediate. Required: wvalid drops after 1 cycle, awvalid stays high until its handshake, and exactly one response is emitted.
- **Error paths:** slave returns bresp=10 and gives resp_err=1. With the macro defined, a word load at 0x102 gives resp_err=1 after 1 cycle with no arvalid asserted.
- **Reset mid-operation:** assert rstn=0 while in WR_RESP. Required: next cycle all valids are 0, bready=0, req_ready=1, and no resp_valid pulse.
